// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, logo bitmap and FSM state type for the write arbiter.
// The logo ROM lookup is only compiled in when FB_LOGO_EN is defined.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 256;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_ABITS  = 16;
  localparam int unsigned COLOR_W   = 6;
  localparam int unsigned LOGO_W    = 65;
  localparam int unsigned LOGO_H    = 13;

  localparam logic [FB_ABITS-1:0] FB_PIXELS = FB_ABITS'(FB_WIDTH * FB_HEIGHT);
  localparam logic [FB_ABITS-1:0] FILL_LAST = FB_ABITS'(FB_WIDTH * FB_HEIGHT - 1);

  // Row 0 is the top logo row; within a row the MSB is the leftmost pixel.
  localparam logic [LOGO_W-1:0] LOGO_BITMAP [LOGO_H] = '{
    65'h1_FFFF_FFFF_FFFF_FFFF,
    65'h1_0000_0000_0000_0001,
    65'h1_3C7E_3C7E_0C3C_7E01,
    65'h1_6666_6060_1C66_6001,
    65'h1_6666_6060_3C66_6001,
    65'h1_7E7C_3C7C_0C66_7C01,
    65'h1_6666_0666_0C66_6001,
    65'h1_6666_0666_0C66_6001,
    65'h1_667E_3C7E_3F3C_7E01,
    65'h1_0000_0000_0000_0001,
    65'h1_5555_5555_5555_5555,
    65'h1_0000_0000_0000_0001,
    65'h1_FFFF_FFFF_FFFF_FFFF
  };

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // Bitmap lookup relative to the logo's top-left corner; outside the logo reads as 0.
  function automatic logic logo_bit(input logic [6:0] dx, input logic [3:0] dy);
    logic [6:0] col;
    col      = 7'(LOGO_W - 1) - dx;
    logo_bit = 1'b0;
    if (dx < 7'(LOGO_W) && dy < 4'(LOGO_H))
      logo_bit = LOGO_BITMAP[dy][col];
  endfunction

endpackage

// File: rtl/fb_fill_gen.sv
// Background fill sequencer: row-major address counter plus logo overlay colour.
// FB_LOGO_EN compiles in the logo ROM; otherwise every fill pixel is BG_COLOR.
module fb_fill_gen
  import fb_pkg::*;
#(
  parameter logic [COLOR_W-1:0] BG_COLOR   = 6'd13,
  parameter logic [COLOR_W-1:0] LOGO_COLOR = 6'd4,
  parameter int unsigned        LOGO_X     = 96,
  parameter int unsigned        LOGO_Y     = 212
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_restart,
  output logic [FB_ABITS-1:0] o_addr,
  output logic [COLOR_W-1:0]  o_data,
  output logic                o_last
);

  localparam logic [8:0] X_LO = 9'(LOGO_X);
  localparam logic [8:0] X_HI = 9'(LOGO_X + LOGO_W);
  localparam logic [8:0] Y_LO = 9'(LOGO_Y);
  localparam logic [8:0] Y_HI = 9'(LOGO_Y + LOGO_H);

  logic [FB_ABITS-1:0] r_cnt;
  logic [7:0]          w_x;
  logic [7:0]          w_y;
  logic                w_in_win;
  logic                w_rom_bit;
  logic                w_logo_hit;

  // Counter wraps to 0 after the last pixel so the next fill starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last ? '0 : r_cnt + FB_ABITS'(1);
    end
  end

  assign w_x      = r_cnt[7:0];
  assign w_y      = r_cnt[15:8];
  assign w_in_win = ({1'b0, w_x} >= X_LO) && ({1'b0, w_x} < X_HI) &&
                    ({1'b0, w_y} >= Y_LO) && ({1'b0, w_y} < Y_HI);

`ifdef FB_LOGO_EN
  logic [6:0] w_dx;
  logic [3:0] w_dy;

  assign w_dx      = 7'(w_x - X_LO[7:0]);
  assign w_dy      = 4'(w_y - Y_LO[7:0]);
  assign w_rom_bit = logo_bit(w_dx, w_dy);
`else
  assign w_rom_bit = 1'b0;
`endif

  assign w_logo_hit = w_in_win & w_rom_bit;
  assign o_addr     = r_cnt;
  assign o_data     = w_logo_hit ? LOGO_COLOR : BG_COLOR;
  assign o_last     = (r_cnt == FILL_LAST);

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: background fill, then PPU pixels with priority over OSD writes.
// Define FB_LOGO_EN to overlay the logo bitmap during the fill.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter logic [COLOR_W-1:0] BG_COLOR   = 6'd13,
  parameter logic [COLOR_W-1:0] LOGO_COLOR = 6'd4,
  parameter int unsigned        LOGO_X     = 96,
  parameter int unsigned        LOGO_Y     = 212
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_valid,
  input  logic [7:0]          pix_x,
  input  logic [8:0]          pix_y,
  input  logic [COLOR_W-1:0]  pix_color,
  input  logic                osd_valid,
  output logic                osd_ready,
  input  logic [FB_ABITS-1:0] osd_addr,
  input  logic [COLOR_W-1:0]  osd_color,
  input  logic                clear_req,
  output logic                fb_we,
  output logic [FB_ABITS-1:0] fb_addr,
  output logic [COLOR_W-1:0]  fb_wdata,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  fsm_state_t          r_state;
  logic                r_fb_we;
  logic [FB_ABITS-1:0] r_fb_addr;
  logic [COLOR_W-1:0]  r_fb_wdata;
  logic                r_busy;
  logic [7:0]          r_drop_cnt;

  logic                w_run;
  logic                w_pix_wr;
  logic                w_osd_acc;
  logic                w_osd_wr;
  logic                w_clear;
  logic [FB_ABITS-1:0] w_fill_addr;
  logic [COLOR_W-1:0]  w_fill_data;
  logic                w_fill_last;

  fb_fill_gen #(
    .BG_COLOR   (BG_COLOR),
    .LOGO_COLOR (LOGO_COLOR),
    .LOGO_X     (LOGO_X),
    .LOGO_Y     (LOGO_Y)
  ) u_fill_gen (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_state == FILL),
    .i_restart (w_clear),
    .o_addr    (w_fill_addr),
    .o_data    (w_fill_data),
    .o_last    (w_fill_last)
  );

  // PPU always wins; OSD only moves on cycles without a pixel strobe.
  assign w_run     = (r_state == RUN);
  assign w_pix_wr  = w_run && pix_valid && (pix_y < 9'(FB_HEIGHT));
  assign w_osd_acc = w_run && osd_valid && !pix_valid;
  assign w_osd_wr  = w_osd_acc && (osd_addr < FB_PIXELS);
  assign w_clear   = w_run && clear_req;
  assign osd_ready = w_run && !pix_valid;

  // busy stays high through the final visible fill write, then drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FILL;
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_wdata <= '0;
      r_busy     <= 1'b1;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        FILL: begin
          r_fb_we    <= 1'b1;
          r_fb_addr  <= w_fill_addr;
          r_fb_wdata <= w_fill_data;
          r_busy     <= 1'b1;
          if (pix_valid && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
          if (w_fill_last)
            r_state <= RUN;
        end
        RUN: begin
          r_fb_we <= w_pix_wr || w_osd_wr;
          if (w_pix_wr) begin
            r_fb_addr  <= {pix_y[7:0], pix_x};
            r_fb_wdata <= pix_color;
          end else if (w_osd_wr) begin
            r_fb_addr  <= osd_addr;
            r_fb_wdata <= osd_color;
          end
          r_busy <= w_clear;
          if (w_clear) begin
            r_state    <= FILL;
            r_drop_cnt <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign fb_we    = r_fb_we;
  assign fb_addr  = r_fb_addr;
  assign fb_wdata = r_fb_wdata;
  assign busy     = r_busy;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: fill model plus a scoreboard queue for RUN-phase writes.
// Expected fill colours follow FB_LOGO_EN the same way the design build does.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [5:0]  data;
  } wr_t;

`ifdef FB_LOGO_EN
  localparam logic [5:0] EXP_SPOT_A = 6'd4;
`else
  localparam logic [5:0] EXP_SPOT_A = 6'd13;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [8:0]  pix_y;
  logic [5:0]  pix_color;
  logic        osd_valid;
  logic        osd_ready;
  logic [15:0] osd_addr;
  logic [5:0]  osd_color;
  logic        clear_req;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [5:0]  fb_wdata;
  logic        busy;
  logic [7:0]  drop_cnt;

  int          checks = 0;
  int          errors = 0;
  wr_t         sb[$];
  bit          fill_mode = 1'b0;
  bit          fill_done = 1'b0;
  int          fill_cnt = 0;
  int          fill_ticks = 0;
  int          fill_bad = 0;
  logic [15:0] exp_fill_addr = 16'h0;
  logic [5:0]  spot_a = 6'h3F;
  logic [5:0]  spot_b = 6'h3F;

  always #5 clk = ~clk;

  fb_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .osd_valid (osd_valid),
    .osd_ready (osd_ready),
    .osd_addr  (osd_addr),
    .osd_color (osd_color),
    .clear_req (clear_req),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  // Reference fill colour; logo at (96,212), bitmap MSB = leftmost pixel.
  function automatic logic [5:0] fill_color(input logic [15:0] a);
`ifdef FB_LOGO_EN
    int x;
    int y;
    x = int'(a[7:0]) - 96;
    y = int'(a[15:8]) - 212;
    fill_color = 6'd13;
    if (x >= 0 && x < 65 && y >= 0 && y < 13)
      if (LOGO_BITMAP[4'(y)][7'(64 - x)]) fill_color = 6'd4;
`else
    fill_color = (a < 16'hF000) ? 6'd13 : 6'h3F;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic observe();
    wr_t e;
    if (fill_mode) begin
      fill_ticks++;
      if (fb_we === 1'b1) begin
        fill_cnt++;
        if (fb_addr !== exp_fill_addr || fb_wdata !== fill_color(exp_fill_addr)) fill_bad++;
        if (fb_addr == 16'hD460) spot_a = fb_wdata;
        if (fb_addr == 16'hD561) spot_b = fb_wdata;
        if (fb_addr == 16'hEFFF) begin
          fill_mode = 1'b0;
          fill_done = 1'b1;
        end
        exp_fill_addr = exp_fill_addr + 16'd1;
      end
    end else if (fb_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected fb_we addr", 32'(fb_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("fb_addr", 32'(fb_addr), 32'(e.addr));
        chk("fb_wdata", 32'(fb_wdata), 32'(e.data));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_fill_tally();
    fill_mode     = 1'b1;
    fill_done     = 1'b0;
    exp_fill_addr = 16'h0;
    fill_cnt      = 0;
    fill_ticks    = 0;
    fill_bad      = 0;
  endtask

  task automatic drive_pix(input logic [7:0] x, input logic [8:0] y, input logic [5:0] c);
    pix_valid = 1'b1;
    pix_x     = x;
    pix_y     = y;
    pix_color = c;
  endtask

  initial begin
    int guard;
    reset = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    osd_valid = 1'b0; osd_addr = '0; osd_color = '0; clear_req = 1'b0;
    #1;
    chk("reset fb_we", 32'(fb_we), 32'd0);
    chk("reset fb_addr", 32'(fb_addr), 32'd0);
    chk("reset fb_wdata", 32'(fb_wdata), 32'd0);
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
    chk("reset osd_ready", 32'(osd_ready), 32'd0);
    ticks(3);

    // Partial fill interrupted by reset at address 0x1234.
    reset = 1'b0;
    start_fill_tally();
    guard = 0;
    while (exp_fill_addr != 16'h1235 && guard < 6000) begin
      tick();
      guard++;
    end
    chk("fill0 reached 0x1234", 32'(exp_fill_addr), 32'h1235);
    chk("fill0 write errors", 32'(fill_bad), 32'd0);
    reset = 1'b1;
    fill_mode = 1'b0;
    #1;
    chk("midrst fb_we", 32'(fb_we), 32'd0);
    chk("midrst fb_addr", 32'(fb_addr), 32'd0);
    chk("midrst fb_wdata", 32'(fb_wdata), 32'd0);
    chk("midrst busy", 32'(busy), 32'd1);
    chk("midrst osd_ready", 32'(osd_ready), 32'd0);
    ticks(2);

    // Full fill from 0, with dropped pixels and a pending OSD request.
    reset = 1'b0;
    start_fill_tally();
    drive_pix(8'd3, 9'd10, 6'h01);
    osd_valid = 1'b1; osd_addr = 16'h0100; osd_color = 6'h02;
    #1;
    chk("osd_ready in FILL", 32'(osd_ready), 32'd0);
    ticks(254);
    chk("drop_cnt 254", 32'(drop_cnt), 32'd254);
    tick();
    chk("drop_cnt 255", 32'(drop_cnt), 32'd255);
    ticks(45);
    chk("drop_cnt saturated", 32'(drop_cnt), 32'd255);
    pix_valid = 1'b0;
    osd_valid = 1'b0;
    guard = 0;
    while (!fill_done && guard < 70000) begin
      tick();
      guard++;
    end
    chk("fill1 completed", 32'(fill_done), 32'd1);
    chk("fill1 write count", 32'(fill_cnt), 32'd61440);
    chk("fill1 no gaps", 32'(fill_ticks), 32'(fill_cnt));
    chk("fill1 write errors", 32'(fill_bad), 32'd0);
    chk("fill1 logo corner", 32'(spot_a), 32'(EXP_SPOT_A));
    chk("fill1 bg pixel", 32'(spot_b), 32'd13);
    tick();
    chk("busy after fill", 32'(busy), 32'd0);
    chk("idle fb_we after fill", 32'(fb_we), 32'd0);
    chk("osd_ready in RUN", 32'(osd_ready), 32'd1);

    // PPU pixel write.
    drive_pix(8'd5, 9'd10, 6'h21);
    sb.push_back('{16'h0A05, 6'h21});
    tick();
    pix_valid = 1'b0;
    chk("pix write latency", 32'(sb.size()), 32'd0);
    tick();
    chk("idle fb_we", 32'(fb_we), 32'd0);

    // Off-screen pixel is ignored and not counted.
    drive_pix(8'd3, 9'd240, 6'h11);
    tick();
    pix_valid = 1'b0;
    chk("y240 ignored", 32'(fb_we), 32'd0);
    chk("y240 not counted", 32'(drop_cnt), 32'd255);

    // Last visible pixel.
    drive_pix(8'd255, 9'd239, 6'h3F);
    sb.push_back('{16'hEFFF, 6'h3F});
    tick();
    pix_valid = 1'b0;
    chk("pix 255,239 write", 32'(sb.size()), 32'd0);

    // PPU wins over OSD for 3 cycles; OSD accepted on cycle 4, written on cycle 5.
    osd_valid = 1'b1; osd_addr = 16'h1020; osd_color = 6'h15;
    for (int i = 0; i < 3; i++) begin
      drive_pix(8'(i + 1), 9'd1, 6'(i + 1));
      sb.push_back('{{8'd1, 8'(i + 1)}, 6'(i + 1)});
      #1;
      chk("osd_ready blocked", 32'(osd_ready), 32'd0);
      tick();
    end
    pix_valid = 1'b0;
    #1;
    chk("osd_ready free", 32'(osd_ready), 32'd1);
    sb.push_back('{16'h1020, 6'h15});
    tick();
    osd_valid = 1'b0;
    chk("osd write cycle 5", 32'(sb.size()), 32'd0);

    // OSD beyond the frame completes but does not write; 0xEFFF does.
    osd_valid = 1'b1; osd_addr = 16'hF000; osd_color = 6'h2A;
    #1;
    chk("osd_ready F000", 32'(osd_ready), 32'd1);
    tick();
    osd_valid = 1'b0;
    chk("osd F000 no write", 32'(fb_we), 32'd0);
    osd_valid = 1'b1; osd_addr = 16'hEFFF; osd_color = 6'h07;
    sb.push_back('{16'hEFFF, 6'h07});
    tick();
    osd_valid = 1'b0;
    chk("osd EFFF write", 32'(sb.size()), 32'd0);

    // clear_req in RUN with a same-cycle pixel.
    clear_req = 1'b1;
    drive_pix(8'd7, 9'd3, 6'h0A);
    sb.push_back('{16'h0307, 6'h0A});
    tick();
    clear_req = 1'b0;
    pix_valid = 1'b0;
    chk("clear busy", 32'(busy), 32'd1);
    chk("clear drop_cnt", 32'(drop_cnt), 32'd0);
    chk("clear same-cycle pix", 32'(sb.size()), 32'd0);
    start_fill_tally();

    // Refill: counted drops, and a second clear_req must not restart it.
    drive_pix(8'd9, 9'd5, 6'h03);
    ticks(3);
    pix_valid = 1'b0;
    chk("fill2 drop_cnt", 32'(drop_cnt), 32'd3);
    ticks(100);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    ticks(200);
    chk("fill2 busy", 32'(busy), 32'd1);
    chk("fill2 no gaps", 32'(fill_cnt), 32'(fill_ticks));
    chk("fill2 write errors", 32'(fill_bad), 32'd0);
    chk("fill2 no restart", 32'(fb_addr), 32'd303);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
